// File: rtl/seg7_count_monitor.sv
// Seven-segment digit monitor: synchronizes and debounces a display bus,
// decodes stable BCD digits and classifies each new digit as step up/down or jump.
module seg7_count_monitor #(
    parameter int STABLE_CYC = 4,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       clr,
    output logic [3:0] digit_out,
    output logic       digit_valid,
    output logic       step_up,
    output logic       step_down,
    output logic       jump,
    output logic       blank,
    output logic       err_code,
    output logic [7:0] step_cnt
);
    localparam logic [3:0] STABLE = 4'(STABLE_CYC);

    typedef enum logic {EMPTY, TRACK} state_t;

    state_t     state_q;
    logic [6:0] sync1_q, sync2_q, cand_q;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] digit_q;
    logic       valid_q, up_q, down_q, jump_q, blank_q, err_q;
    logic [7:0] step_cnt_q;

    logic [6:0] s;
    logic       differs, stable_ev, dec_ok, accept, is_up, is_down;
    logic [3:0] dec_digit, next_digit, prev_digit;

    function automatic logic [4:0] decode(input logic [6:0] code);
        case (code)
            7'h3F:   decode = {1'b1, 4'd0};
            7'h06:   decode = {1'b1, 4'd1};
            7'h5B:   decode = {1'b1, 4'd2};
            7'h4F:   decode = {1'b1, 4'd3};
            7'h66:   decode = {1'b1, 4'd4};
            7'h6D:   decode = {1'b1, 4'd5};
            7'h7D:   decode = {1'b1, 4'd6};
            7'h07:   decode = {1'b1, 4'd7};
            7'h7F:   decode = {1'b1, 4'd8};
            7'h6F:   decode = {1'b1, 4'd9};
            default: decode = {1'b0, 4'd0};
        endcase
    endfunction

    assign s       = ACTIVE_LOW ? ~sync2_q : sync2_q;
    assign differs = (s != cand_q);

    always_comb begin
        cnt_d = cnt_q;
        if (differs)             cnt_d = 4'd1;
        else if (cnt_q != STABLE) cnt_d = cnt_q + 4'd1;
    end

    // The stable event fires on the edge the counter arrives at STABLE, so the
    // registered result lands exactly 2+STABLE_CYC cycles after the input change.
    assign stable_ev = (cnt_d == STABLE) && (differs || cnt_q != STABLE);

    assign {dec_ok, dec_digit} = decode(s);
    assign next_digit = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    assign prev_digit = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    assign is_up      = (dec_digit == next_digit);
    assign is_down    = (dec_digit == prev_digit);
    assign accept     = stable_ev && dec_ok && (state_q == EMPTY || dec_digit != digit_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            digit_q    <= '0;
            valid_q    <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            jump_q     <= 1'b0;
            blank_q    <= 1'b0;
            err_q      <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            sync1_q <= seg_in;
            sync2_q <= sync1_q;
            cand_q  <= s;
            cnt_q   <= cnt_d;
            valid_q <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            jump_q  <= 1'b0;

            if (stable_ev) begin
                blank_q <= (s == 7'h00);
                if (s != 7'h00 && !dec_ok) err_q <= 1'b1;
            end

            if (accept) begin
                digit_q <= dec_digit;
                valid_q <= 1'b1;
                state_q <= TRACK;
                if (state_q == TRACK) begin
                    up_q   <= is_up;
                    down_q <= is_down;
                    jump_q <= !is_up && !is_down;
                end
            end

            if (clr) begin
                step_cnt_q <= '0;
                err_q      <= 1'b0;
            end else if (accept && step_cnt_q != 8'hFF) begin
                step_cnt_q <= step_cnt_q + 8'd1;
            end
        end
    end

    assign digit_out   = digit_q;
    assign digit_valid = valid_q;
    assign step_up     = up_q;
    assign step_down   = down_q;
    assign jump        = jump_q;
    assign blank       = blank_q;
    assign err_code    = err_q;
    assign step_cnt    = step_cnt_q;
endmodule

// File: tb/tb_seg7_count_monitor.sv
// Directed bench for seg7_count_monitor (STABLE_CYC=4, active-low bus).
module tb_seg7_count_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] seg_in;
    logic       clr = 1'b0;
    logic [3:0] digit_out;
    logic       digit_valid, step_up, step_down, jump, blank, err_code;
    logic [7:0] step_cnt;

    int total = 0;
    int bad   = 0;
    int n_valid = 0, n_up = 0, n_down = 0, n_jump = 0;
    int b_valid, b_up, b_down, b_jump;

    logic [6:0] code_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seg7_count_monitor #(.STABLE_CYC(4), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .clr(clr),
        .digit_out(digit_out), .digit_valid(digit_valid),
        .step_up(step_up), .step_down(step_down), .jump(jump),
        .blank(blank), .err_code(err_code), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (digit_valid) n_valid++;
        if (step_up)     n_up++;
        if (step_down)   n_down++;
        if (jump)        n_jump++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [6:0] code);
        seg_in = ~code;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_valid = n_valid; b_up = n_up; b_down = n_down; b_jump = n_jump;
    endtask

    task automatic hold_digit(input int d);
        put(code_tab[d]);
        cyc(10);
    endtask

    initial begin
        put(7'h5B);
        cyc(3);
        chk("rst_digit", digit_out, 0);
        chk("rst_valid", digit_valid, 0);
        chk("rst_cnt", step_cnt, 0);
        chk("rst_flags", {blank, err_code, step_up, step_down, jump}, 0);

        // first digit after release: exact latency, no step classification
        rst = 1'b1;
        snap();
        for (int i = 1; i <= 6; i++) begin
            cyc(1);
            chk($sformatf("lat_valid_%0d", i), digit_valid, (i == 6) ? 1 : 0);
        end
        chk("first_digit", digit_out, 2);
        chk("first_steps", (n_up - b_up) + (n_down - b_down) + (n_jump - b_jump), 0);
        chk("first_cnt", step_cnt, 1);

        clr = 1'b1; cyc(1); clr = 1'b0;
        chk("clr_cnt", step_cnt, 0);

        // 2->7 jump, then 7,8,9,0 up including wrap, then 0->9 down
        hold_digit(7);
        snap();
        hold_digit(8); hold_digit(9); hold_digit(0);
        chk("up_pulses", n_up - b_up, 3);
        chk("up_other", (n_down - b_down) + (n_jump - b_jump), 0);
        chk("up_cnt", step_cnt, 4);
        chk("up_digit", digit_out, 0);
        snap();
        hold_digit(9);
        chk("down_pulse", n_down - b_down, 1);
        chk("down_digit", digit_out, 9);

        // load-style jump, then short glitch that must be ignored
        hold_digit(3);
        snap();
        hold_digit(7);
        chk("jump_pulse", n_jump - b_jump, 1);
        chk("jump_digit", digit_out, 7);
        snap();
        put(code_tab[8]); cyc(2);
        hold_digit(7);
        chk("glitch_valid", n_valid - b_valid, 0);
        chk("glitch_digit", digit_out, 7);

        // blank and return to the same digit
        snap();
        put(7'h00); cyc(10);
        chk("blank_set", blank, 1);
        chk("blank_digit", digit_out, 7);
        hold_digit(7);
        chk("blank_clr", blank, 0);
        chk("blank_valid", n_valid - b_valid, 0);

        // invalid pattern, then clear
        put(7'h49); cyc(10);
        chk("err_set", err_code, 1);
        chk("err_digit", digit_out, 7);
        chk("err_valid", n_valid - b_valid, 0);
        clr = 1'b1; cyc(1); clr = 1'b0;
        chk("err_clr", err_code, 0);
        chk("err_cnt", step_cnt, 0);

        // saturation of step_cnt
        for (int i = 0; i < 260; i++) begin
            put(code_tab[(i % 2) + 1]);
            cyc(7);
        end
        chk("sat_cnt", step_cnt, 255);

        // reset two cycles into qualification of a new digit
        put(code_tab[5]); cyc(2);
        rst = 1'b0; #1;
        chk("midrst_digit", digit_out, 0);
        chk("midrst_cnt", step_cnt, 0);
        chk("midrst_flags", {digit_valid, blank, err_code, step_up, step_down, jump}, 0);
        cyc(2);
        rst = 1'b1;
        snap();
        for (int i = 1; i <= 6; i++) begin
            cyc(1);
            chk($sformatf("rel_valid_%0d", i), digit_valid, (i == 6) ? 1 : 0);
        end
        chk("rel_digit", digit_out, 5);
        chk("rel_steps", (n_up - b_up) + (n_down - b_down) + (n_jump - b_jump), 0);
        chk("rel_cnt", step_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg7_count_monitor.md
SEG7_COUNT_MONITOR -- requirements
Module: seg7_count_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 4, meaning the number of consecutive identical synchronized samples (range 1..15) required before a code is accepted.
REQ-002 SHALL have parameter ACTIVE_LOW, default 1, meaning the segment bus is active-low; 0 means active-high.
REQ-003 SHALL have port clk  input  1  system clock, rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port seg_in  input  7  seven-segment bus, bit0=a ... bit6=g, asynchronous to clk.
REQ-006 SHALL have port clr  input  1  synchronous clear of step_cnt and sticky error flags.
REQ-007 SHALL have port digit_out  output  4  last accepted BCD digit, 0..9.
REQ-008 SHALL have port digit_valid  output  1  one-cycle pulse on each accepted new digit.
REQ-009 SHALL have port step_up  output  1  one-cycle pulse: the accepted digit equals the previous digit +1 mod 10.
REQ-010 SHALL have port step_down  output  1  one-cycle pulse: the accepted digit equals the previous digit -1 mod 10.
REQ-011 SHALL have port jump  output  1  one-cycle pulse: the accepted digit is neither +1 nor -1 mod 10 from the previous digit (e.g. a load).
REQ-012 SHALL have port blank  output  1  level: the current stable code is all segments off.
REQ-013 SHALL have port err_code  output  1  sticky: a stable non-blank, non-decimal pattern was seen.
REQ-014 SHALL have port step_cnt  output  8  saturating count of digit_valid pulses.

Function
REQ-015 SHALL pass seg_in through a 2-flop synchronizer; when ACTIVE_LOW=1 it SHALL invert the result to obtain active-high code s.
REQ-016 SHALL hold a candidate register and a stability counter: when s differs from the candidate, load the candidate and set the counter to 1; otherwise increment the counter, saturating at STABLE_CYC.
REQ-017 SHALL declare the candidate stable in the cycle in which the counter reaches STABLE_CYC; each stable event SHALL be evaluated exactly once.
REQ-018 SHALL decode active-high gfedcba codes strictly as 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex); every other code except 00 is invalid.
REQ-019 SHALL use FSM states EMPTY (no digit accepted yet) and TRACK.
REQ-020 On a stable valid code in EMPTY: update digit_out, pulse digit_valid only, do not pulse step_up, step_down or jump, and go to TRACK.
REQ-021 On a stable valid code in TRACK that differs from digit_out: update digit_out, pulse digit_valid, and pulse exactly one of step_up, step_down or jump; wrap cases SHALL apply (9->0 is up, 0->9 is down).
REQ-022 On a stable valid code in TRACK equal to digit_out (for example after a blank or a glitch): no pulse and no change.
REQ-023 A stable code of 00 SHALL set blank=1 and leave digit_out and the FSM unchanged; blank SHALL clear on the next stable non-blank code.
REQ-024 A stable invalid code SHALL set err_code and leave digit_out and the FSM unchanged.
REQ-025 A code change shorter than STABLE_CYC cycles SHALL produce no output change.
REQ-026 Latency from a seg_in change to digit_valid SHALL be exactly 2+STABLE_CYC clk cycles.
REQ-027 step_cnt SHALL increment on each digit_valid and saturate at 255.
REQ-028 clr=1 SHALL zero step_cnt and err_code on the next edge; clr has priority over a simultaneous increment; clr SHALL NOT affect digit_out, the FSM or blank.
REQ-029 All pulse outputs SHALL be registered and mutually consistent within the same cycle.

Reset
REQ-030 While rst=0: synchronizer, candidate, counter, digit_out, step_cnt, err_code, blank and all pulses = 0; FSM = EMPTY.
REQ-031 Reset asserted mid-qualification SHALL discard the pending candidate; after release, the code SHALL qualify from scratch with full latency.

Verification
REQ-032 Reset released, ACTIVE_LOW=1, seg_in=~7'h5B held: digit_valid pulses 6 cycles later, digit_out=2, no step pulse, step_cnt=1.
REQ-033 Up sequence 7,8,9,0, each held 10 cycles: three step_up pulses (9->0 included), step_cnt=4; then down sequence 0->9: step_down pulse.
REQ-034 Digit 3 then 7 (load-style jump): jump pulse, digit_out=7; a 2-cycle glitch to 8 then back to 7: no pulse.
REQ-035 seg_in=~7'h00 (all off) stable: blank=1, digit_out unchanged; returning to the same digit: blank=0, no pulse.
REQ-036 seg_in=~7'h49 stable: err_code=1, digit_out unchanged; clr pulse: err_code=0 and step_cnt=0 on the next cycle.
REQ-037 Reset pulsed 2 cycles into qualification of a new digit: all outputs 0, FSM EMPTY; the held code qualifies 6 cycles after release with no step pulse.
